// File: rtl/intdiv_sequencer_pkg.sv
// Shared types and constants for the iterative integer divider.
package intdiv_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } divstate_t;

  localparam int MAX_XLEN = 64;
  localparam int CNT_W    = $clog2(MAX_XLEN);

endpackage

// File: rtl/intdiv_step.sv
// One radix-2 restoring iteration: shift {R,Q} left, trial-subtract D, keep if non-negative.
module intdiv_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] remIn,
  input  logic [W-1:0] quoIn,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] remOut,
  output logic [W-1:0] quoOut
);

  logic [W:0]   shifted;
  logic [W+1:0] trial;
  logic         fits;

  // Shifted remainder can reach 2*D-1, so the trial needs two guard bits.
  always_comb begin
    shifted = {remIn, quoIn[W-1]};
    trial   = {1'b0, shifted} - {2'b00, divisor};
    fits    = ~trial[W+1];
    remOut  = fits ? trial[W-1:0] : shifted[W-1:0];
    quoOut  = {quoIn[W-2:0], fits};
  end

endmodule

// File: rtl/intdiv_sequencer.sv
// Execute-stage DIV/DIVU/REM/REMU (and W-forms) controller around a restoring step.
// Handshake: IntDivE launches from IDLE; DivBusyE stalls the pipe until DONE, where
// DivResultE is valid; the op retires the first DONE cycle with StallE low.
module intdiv_sequencer
  import intdiv_sequencer_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IntDivE,
  input  logic            FlushE,
  input  logic            StallE,
  input  logic            W64E,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  output logic            DivBusyE,
  output logic [XLEN-1:0] DivResultE,
  output logic [1:0]      DivStateE
);

  divstate_t        state, nextState;
  logic [CNT_W-1:0] counter;
  logic [XLEN-1:0]  remR, quoQ, divD;
  logic             negQ, negR, isW, remSel, bypassFix;

  logic [XLEN-1:0]  srcA, srcB, absA, absB, qInit, remNext, quoNext;
  logic [XLEN-1:0]  fixQ, fixR, picked;
  logic             isSigned, signA, signB, divZero, overflow;

  // Operands at the active width, widened so one datapath serves both forms.
  always_comb begin
    isSigned = ~Funct3E[0];
    if (W64E) begin
      srcA = isSigned ? XLEN'($signed(ForwardedSrcAE[31:0])) : XLEN'(ForwardedSrcAE[31:0]);
      srcB = isSigned ? XLEN'($signed(ForwardedSrcBE[31:0])) : XLEN'(ForwardedSrcBE[31:0]);
    end else begin
      srcA = ForwardedSrcAE;
      srcB = ForwardedSrcBE;
    end
    signA    = isSigned & srcA[XLEN-1];
    signB    = isSigned & srcB[XLEN-1];
    absA     = signA ? -srcA : srcA;
    absB     = signB ? -srcB : srcB;
    divZero  = (srcB == '0);
    overflow = isSigned & (&srcB) & (W64E ? (srcA[31:0] == 32'h8000_0000)
                                          : (srcA == {1'b1, {(XLEN-1){1'b0}}}));
    // W-form dividend sits in the upper half so 32 shifts drain it completely.
    qInit    = W64E ? (absA << (XLEN - 32)) : absA;
  end

  intdiv_step #(.W(XLEN)) u_step (
    .remIn  (remR),
    .quoIn  (quoQ),
    .divisor(divD),
    .remOut (remNext),
    .quoOut (quoNext)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (IntDivE)              nextState = PREP;
      PREP: nextState = (divZero | overflow) ? DONE : BUSY;
      BUSY: if (counter == '0)        nextState = DONE;
      DONE: if (!StallE)              nextState = IDLE;
    endcase
    if (FlushE) nextState = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter   <= '0;
      remR      <= '0;
      quoQ      <= '0;
      divD      <= '0;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      isW       <= 1'b0;
      remSel    <= 1'b0;
      bypassFix <= 1'b0;
    end else if (state == PREP) begin
      negQ      <= signA ^ signB;
      negR      <= signA;
      isW       <= W64E;
      remSel    <= Funct3E[1];
      divD      <= absB;
      counter   <= W64E ? CNT_W'(31) : CNT_W'(XLEN - 1);
      bypassFix <= divZero | overflow;
      if (divZero) begin
        quoQ <= '1;
        remR <= srcA;
      end else if (overflow) begin
        quoQ <= srcA;
        remR <= '0;
      end else begin
        quoQ <= qInit;
        remR <= '0;
      end
    end else if (state == BUSY) begin
      remR    <= remNext;
      quoQ    <= quoNext;
      counter <= counter - 1'b1;
    end
  end

  always_comb begin
    DivStateE  = state;
    DivBusyE   = ((state == IDLE) & IntDivE & ~FlushE) | (state == PREP) | (state == BUSY);
    fixQ       = (negQ & ~bypassFix) ? -quoQ : quoQ;
    fixR       = (negR & ~bypassFix) ? -remR : remR;
    picked     = remSel ? fixR : fixQ;
    DivResultE = '0;
    if (state == DONE)
      DivResultE = isW ? XLEN'($signed(picked[31:0])) : picked;
  end

endmodule

// File: tb/tb_intdiv_sequencer.sv
// Randomised and directed bench for intdiv_sequencer against an arithmetic reference model.
module tb_intdiv_sequencer;
  import intdiv_sequencer_pkg::*;

  logic        clk, reset, IntDivE, FlushE, StallE, W64E;
  logic [2:0]  Funct3E;
  logic [63:0] SrcA, SrcB;
  logic        DivBusyE;
  logic [63:0] DivResultE;
  logic [1:0]  DivStateE;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];

  intdiv_sequencer #(.XLEN(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .IntDivE       (IntDivE),
    .FlushE        (FlushE),
    .StallE        (StallE),
    .W64E          (W64E),
    .Funct3E       (Funct3E),
    .ForwardedSrcAE(SrcA),
    .ForwardedSrcBE(SrcB),
    .DivBusyE      (DivBusyE),
    .DivResultE    (DivResultE),
    .DivStateE     (DivStateE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RISC-V division semantics from plain integer arithmetic.
  function automatic logic [63:0] refDiv(input logic [2:0] f3, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
    logic        uns, rem;
    logic [31:0] ua, ub, r32;
    int          sa, sb;
    longint      la, lb;
    logic [63:0] r64;
    uns = f3[0];
    rem = f3[1];
    if (w) begin
      ua = a[31:0];
      ub = b[31:0];
      sa = $signed(ua);
      sb = $signed(ub);
      if (ub == 32'd0)                                          r32 = rem ? ua : 32'hFFFF_FFFF;
      else if (uns)                                             r32 = rem ? ua % ub : ua / ub;
      else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF)      r32 = rem ? 32'd0 : ua;
      else                                                      r32 = rem ? 32'(sa % sb) : 32'(sa / sb);
      return {{32{r32[31]}}, r32};
    end
    la = $signed(a);
    lb = $signed(b);
    if (b == 64'd0)                                             r64 = rem ? a : '1;
    else if (uns)                                               r64 = rem ? a % b : a / b;
    else if (a == 64'h8000_0000_0000_0000 && b == '1)           r64 = rem ? 64'd0 : a;
    else                                                        r64 = rem ? 64'(la % lb) : 64'(la / lb);
    return r64;
  endfunction

  function automatic int expBusyCycles(input logic [2:0] f3, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    if (w) begin
      zero = (b[31:0] == 32'd0);
      ovf  = !f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
      return (zero || ovf) ? 1 : 33;
    end
    zero = (b == 64'd0);
    ovf  = !f3[0] && a == 64'h8000_0000_0000_0000 && b == '1;
    return (zero || ovf) ? 1 : 65;
  endfunction

  // Busy cycles are counted from the cycle after launch; the launch cycle itself is checked separately.
  task automatic runOp(input string name, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input int stallCycles,
                       input bit useExp, input logic [63:0] expVal);
    int          busyCnt;
    logic [63:0] res;
    exp_q.push_back(useExp ? expVal : refDiv(f3, w, a, b));
    @(negedge clk);
    IntDivE = 1'b1; Funct3E = f3; W64E = w; SrcA = a; SrcB = b;
    #1;
    check({name, "_launch_busy"}, 64'(DivBusyE), 64'd1);
    busyCnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!DivBusyE) break;
      busyCnt++;
    end
    check({name, "_busy_cycles"}, 64'(busyCnt), 64'(expBusyCycles(f3, w, a, b)));
    check({name, "_done_state"}, 64'(DivStateE), 64'(DONE));
    res = DivResultE;
    check({name, "_result"}, res, exp_q.pop_front());
    for (int k = 0; k < stallCycles; k++) begin
      StallE = 1'b1;
      @(negedge clk);
      check({name, "_stall_result"}, DivResultE, res);
      check({name, "_stall_busy"}, 64'(DivBusyE), 64'd0);
    end
    StallE = 1'b0;
    @(negedge clk);
    check({name, "_no_relaunch"}, 64'(DivStateE), 64'(IDLE));
    IntDivE = 1'b0;
    #1;
    check({name, "_idle_busy"}, 64'(DivBusyE), 64'd0);
    check({name, "_idle_result"}, DivResultE, 64'd0);
  endtask

  task automatic abortOp(input bit useReset);
    @(negedge clk);
    IntDivE = 1'b1; Funct3E = 3'b100; W64E = 1'b0; SrcA = 64'd1000; SrcB = 64'd3;
    repeat (11) @(negedge clk);
    check("abort_pre_state", 64'(DivStateE), 64'(BUSY));
    if (useReset) begin
      reset = 1'b1; IntDivE = 1'b0;
    end else begin
      FlushE = 1'b1;
    end
    @(negedge clk);
    check("abort_state", 64'(DivStateE), 64'(IDLE));
    check("abort_busy", 64'(DivBusyE), 64'd0);
    check("abort_result", DivResultE, 64'd0);
    reset = 1'b0; FlushE = 1'b0; IntDivE = 1'b0;
    runOp("after_abort_divu", 3'b101, 1'b0, 64'd20, 64'd3, 0, 1'b1, 64'd6);
  endtask

  function automatic logic [63:0] randOperand();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'($urandom_range(0, 40));
      4:       return -64'($urandom_range(1, 40));
      5:       return 64'hFFFF_FFFF_8000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    reset = 1'b1; IntDivE = 1'b0; FlushE = 1'b0; StallE = 1'b0; W64E = 1'b0;
    Funct3E = 3'b000; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    check("reset_state", 64'(DivStateE), 64'(IDLE));
    check("reset_busy", 64'(DivBusyE), 64'd0);
    check("reset_result", DivResultE, 64'd0);
    reset = 1'b0;

    runOp("div_100_m7",   3'b100, 1'b0, 64'd100, -64'd7, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2);
    runOp("rem_100_m7",   3'b110, 1'b0, 64'd100, -64'd7, 0, 1'b1, 64'd2);
    runOp("divuw_ffff",   3'b101, 1'b1, 64'hFFFF_FFFF, 64'd2, 0, 1'b1, 64'h7FFF_FFFF);
    runOp("remw_m9_4",    3'b110, 1'b1, -64'd9, 64'd4, 0, 1'b1, '1);
    runOp("div_5_0",      3'b100, 1'b0, 64'd5, 64'd0, 0, 1'b1, '1);
    runOp("remu_5_0",     3'b111, 1'b0, 64'd5, 64'd0, 0, 1'b1, 64'd5);
    runOp("div_ovf",      3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 0, 1'b1, 64'h8000_0000_0000_0000);
    runOp("rem_ovf",      3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 0, 1'b1, 64'd0);
    runOp("divw_ovf",     3'b100, 1'b1, 64'h8000_0000, '1, 0, 1'b1, 64'hFFFF_FFFF_8000_0000);
    runOp("stall_3",      3'b100, 1'b0, 64'd77, 64'd5, 3, 1'b1, 64'd15);

    abortOp(1'b0);
    abortOp(1'b1);

    for (int n = 0; n < 40; n++) begin
      logic [2:0] f3;
      f3 = {1'b1, 2'($urandom_range(0, 3))};
      runOp("rand", f3, 1'($urandom_range(0, 1)), randOperand(), randOperand(),
            $urandom_range(0, 2), 1'b0, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
